// File: rtl/axi_request_arbiter.sv
// Round-robin arbiter sharing one axi_master request port among N_REQ requesters.
// Write and read channels are arbitrated independently, one outstanding transaction each.
module axi_request_arbiter #(
  parameter int N_REQ   = 2,
  parameter int GRANT_W = $clog2(N_REQ)
) (
  input  logic                 axi_ACLK,
  input  logic                 axi_ARESETN,
  input  logic [N_REQ-1:0]     req_write_i,
  input  logic [N_REQ*32-1:0]  req_write_address_i,
  input  logic [N_REQ*32-1:0]  req_write_data_i,
  input  logic [N_REQ*4-1:0]   req_write_strobe_i,
  output logic [N_REQ-1:0]     req_write_done_o,
  input  logic [N_REQ-1:0]     req_read_i,
  input  logic [N_REQ*32-1:0]  req_read_address_i,
  output logic [N_REQ-1:0]     req_read_done_o,
  output logic [31:0]          read_data_o,
  output logic [1:0]           write_response_o,
  output logic [1:0]           read_response_o,
  output logic [GRANT_W-1:0]   write_grant_o,
  output logic [GRANT_W-1:0]   read_grant_o,
  output logic                 write_start_o,
  output logic [31:0]          write_address_o,
  output logic [31:0]          write_data_o,
  output logic [3:0]           write_strobe_o,
  input  logic                 write_cts_i,
  input  logic                 write_done_i,
  input  logic [1:0]           write_response_i,
  output logic                 read_start_o,
  output logic [31:0]          read_address_o,
  input  logic                 read_cts_i,
  input  logic                 read_done_i,
  input  logic [31:0]          read_data_i,
  input  logic [1:0]           read_response_i,
  output logic                 write_state_o,
  output logic                 read_state_o
);

  // Handshake: a channel launches only from IDLE when its cts input is high and some
  // requester is asserting; start then pulses for one cycle with the payload already
  // registered. The master's done pulse ends the transaction and is forwarded
  // combinationally to the owner only while the channel is BUSY.

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t w_state, w_state_next;
  state_t r_state, r_state_next;
  logic   w_take, r_take;
  logic [GRANT_W-1:0] w_last, r_last, w_pick, r_pick;

  // First requester found scanning upward from last+1 with wrap; the previous owner
  // is therefore visited last.
  function automatic logic [GRANT_W-1:0] rr_pick(input logic [GRANT_W-1:0] last,
                                                 input logic [N_REQ-1:0]   req);
    logic [GRANT_W-1:0] sel;
    int idx;
    sel = last;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = (int'(last) + k) % N_REQ;
      if (req[idx]) sel = GRANT_W'(idx);
    end
    return sel;
  endfunction

  assign w_pick = rr_pick(w_last, req_write_i);
  assign r_pick = rr_pick(r_last, req_read_i);

  // ---------------- write channel ----------------
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) w_state <= IDLE;
    else              w_state <= w_state_next;
  end

  always_comb begin
    w_state_next = w_state;
    w_take       = 1'b0;
    case (w_state)
      IDLE: begin
        if (|req_write_i && write_cts_i) begin
          w_take       = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (write_done_i) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      write_start_o   <= 1'b0;
      write_grant_o   <= '0;
      w_last          <= GRANT_W'(N_REQ - 1);
      write_address_o <= '0;
      write_data_o    <= '0;
      write_strobe_o  <= '0;
    end else begin
      write_start_o <= w_take;
      if (w_take) begin
        write_grant_o   <= w_pick;
        write_address_o <= req_write_address_i[int'(w_pick)*32 +: 32];
        write_data_o    <= req_write_data_i[int'(w_pick)*32 +: 32];
        write_strobe_o  <= req_write_strobe_i[int'(w_pick)*4 +: 4];
      end
      if (w_state == BUSY && write_done_i) w_last <= write_grant_o;
    end
  end

  always_comb begin
    req_write_done_o = '0;
    if (w_state == BUSY && write_done_i) req_write_done_o[write_grant_o] = 1'b1;
  end

  assign write_response_o = write_response_i;
  assign write_state_o    = (w_state == BUSY);

  // ---------------- read channel ----------------
  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) r_state <= IDLE;
    else              r_state <= r_state_next;
  end

  always_comb begin
    r_state_next = r_state;
    r_take       = 1'b0;
    case (r_state)
      IDLE: begin
        if (|req_read_i && read_cts_i) begin
          r_take       = 1'b1;
          r_state_next = BUSY;
        end
      end
      BUSY: begin
        if (read_done_i) r_state_next = IDLE;
      end
      default: r_state_next = IDLE;
    endcase
  end

  always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
    if (!axi_ARESETN) begin
      read_start_o   <= 1'b0;
      read_grant_o   <= '0;
      r_last         <= GRANT_W'(N_REQ - 1);
      read_address_o <= '0;
    end else begin
      read_start_o <= r_take;
      if (r_take) begin
        read_grant_o   <= r_pick;
        read_address_o <= req_read_address_i[int'(r_pick)*32 +: 32];
      end
      if (r_state == BUSY && read_done_i) r_last <= read_grant_o;
    end
  end

  always_comb begin
    req_read_done_o = '0;
    if (r_state == BUSY && read_done_i) req_read_done_o[read_grant_o] = 1'b1;
  end

  assign read_data_o     = read_data_i;
  assign read_response_o = read_response_i;
  assign read_state_o    = (r_state == BUSY);

endmodule
